// File: rtl/tis_pkg.sv
// Shared constants and types for the TIS stream endpoints.
// Both the input-stream source and the output capture use them.
package tis_pkg;

   localparam int WORD_W       = 11;
   localparam int STREAM_DEPTH = 39;
   localparam int LEN_W        = 6;

   typedef logic signed [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCEPT,
      DONE
   } outstream_state_e;

endpackage

// File: rtl/outstream.sv
// Output-side capture channel: accepts up to DEPTH words from a node,
// stores them in order and checks them against a reference array.
module outstream #(
   parameter int WIDTH = tis_pkg::WORD_W,
   parameter int DEPTH = tis_pkg::STREAM_DEPTH,
   parameter int LEN_W = tis_pkg::LEN_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic        [LEN_W-1:0] length,
   input  logic signed [WIDTH-1:0] expected [DEPTH],
   input  logic                    write,
   input  logic signed [WIDTH-1:0] in,
   output logic                    read,
   output logic        [LEN_W-1:0] count,
   output logic signed [WIDTH-1:0] captured [DEPTH],
   output logic                    done,
   output logic                    mismatch,
   output logic        [LEN_W-1:0] err_idx,
   output logic                    pass
);

   import tis_pkg::*;

   outstream_state_e state, state_d;

   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] len_c;
   logic             xfer;
   logic             last;
   logic             read_d;

   assign len_c = (length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : length;
   assign xfer  = write && read;
   assign last  = (count + LEN_W'(1)) == len_q;

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE: begin
            state_d = (len_c == '0) ? DONE : ACCEPT;
         end
         ACCEPT: begin
            if (xfer && last) state_d = DONE;
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      read_d = (state_d == ACCEPT);
   end

   // read is registered so the node never sees a combinational path from write
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         read     <= 1'b0;
         count    <= '0;
         mismatch <= 1'b0;
         err_idx  <= '0;
         len_q    <= '0;
         for (int i = 0; i < DEPTH; i++) captured[i] <= '0;
      end else begin
         state <= state_d;
         read  <= read_d;
         if (state == IDLE) len_q <= len_c;
         if (xfer) begin
            captured[count] <= in;
            count           <= count + LEN_W'(1);
            if ((in != expected[count]) && !mismatch) begin
               mismatch <= 1'b1;
               err_idx  <= count;
            end
         end
      end
   end

   assign done = (state == DONE);
   assign pass = done && !mismatch;

endmodule

// File: tb/tb_outstream.sv
// Randomized self-checking bench for outstream against a
// word-count level model of the capture channel.
module tb_outstream;

   localparam int W = 11;
   localparam int D = 39;
   localparam int L = 6;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic        [L-1:0] length = '0;
   logic signed [W-1:0] expv [D];
   logic                write = 1'b0;
   logic signed [W-1:0] din = '0;
   logic                read;
   logic        [L-1:0] count;
   logic signed [W-1:0] cap [D];
   logic                done;
   logic                mismatch;
   logic        [L-1:0] err_idx;
   logic                pass;

   int words [64];
   int total = 0;
   int bad   = 0;

   outstream dut (
      .clk      (clk),
      .rst      (rst),
      .length   (length),
      .expected (expv),
      .write    (write),
      .in       (din),
      .read     (read),
      .count    (count),
      .captured (cap),
      .done     (done),
      .mismatch (mismatch),
      .err_idx  (err_idx),
      .pass     (pass)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   function automatic int rword();
      return int'($urandom_range(0, 2047)) - 1024;
   endfunction

   task automatic run(input int len, input int wprob,
                      input int hold, input int abort_at);
      int  n, t, acc, ferr, post;
      bit  rd, w, fin, fin_t;
      n    = (len > D) ? D : len;
      acc  = 0;
      ferr = -1;
      t    = 0;
      post = 0;
      fin  = 1'b0;
      length = L'(len);
      write  = 1'b0;
      rst    = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         rd    = (t >= 1) && (acc < n);
         fin_t = (t >= 1) && (acc == n);
         chk("read", int'(read), int'(rd));
         chk("count", int'(count), acc);
         chk("done", int'(done), int'(fin_t));
         chk("mismatch", int'(mismatch), int'(ferr >= 0));
         if (ferr >= 0) chk("err_idx", int'(err_idx), ferr);
         chk("pass", int'(pass), int'(fin_t && ferr < 0));
         if (abort_at > 0 && acc == abort_at) begin
            rst   = 1'b1;
            write = 1'b0;
            @(posedge clk);
            #1;
            chk("rst_read", int'(read), 0);
            chk("rst_count", int'(count), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_mismatch", int'(mismatch), 0);
            chk("rst_err_idx", int'(err_idx), 0);
            chk("rst_pass", int'(pass), 0);
            for (int i = 0; i < D; i++) chk("rst_cap", int'(cap[i]), 0);
            return;
         end
         if (fin_t) begin
            fin = 1'b1;
            post++;
            if (post > 4) break;
         end
         w     = (cyc >= hold) && (int'($urandom_range(0, 99)) < wprob);
         write = w;
         din   = w ? W'(words[acc]) : W'($urandom);
         @(posedge clk);
         if (w && rd) begin
            if (words[acc] != int'(expv[acc]) && ferr < 0) ferr = acc;
            acc++;
         end
         t++;
         @(negedge clk);
      end
      write = 1'b0;
      if (!fin) chk("timeout", 0, 1);
      for (int i = 0; i < D; i++)
         chk("cap", int'(cap[i]), (i < acc) ? words[i] : 0);
   endtask

   task automatic fill(input int errpct);
      for (int i = 0; i < D; i++) expv[i] = W'(rword());
      for (int i = 0; i < 64; i++) begin
         if (i < D && int'($urandom_range(0, 99)) >= errpct)
            words[i] = int'(expv[i]);
         else
            words[i] = rword();
      end
   endtask

   initial begin
      fill(0);
      expv[0] = 11'sd5;
      expv[1] = -11'sd7;
      expv[2] = 11'sd999;
      words[0] = 5;
      words[1] = -7;
      words[2] = 999;
      run(3, 100, 0, 0);

      fill(0);
      for (int i = 0; i < 4; i++) expv[i] = W'(i + 1);
      words[0] = 1;
      words[1] = 9;
      words[2] = 3;
      words[3] = 8;
      run(4, 50, 0, 0);

      fill(0);
      run(0, 50, 0, 0);

      fill(0);
      words[0]  = -1024;
      words[38] = 1023;
      expv[0]   = -11'sd1024;
      expv[38]  = 11'sd1023;
      run(45, 100, 0, 0);

      fill(0);
      expv[0] = 11'sd10;
      words[0] = 11;
      run(5, 100, 0, 2);
      fill(0);
      run(5, 100, 0, 0);

      fill(0);
      run(6, 100, 11, 0);

      for (int k = 0; k < 6; k++) begin
         fill(15);
         run(int'($urandom_range(0, 50)), int'($urandom_range(30, 100)), 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
